pulse_burst_controller: RTL

PULSE_BURST_CONTROLLER -- requirements
Module: pulse_burst_controller

---
 rtl/pulse_ctrl_pkg.sv | 14 +
 rtl/pulse_timer.sv | 27 ++
 rtl/pulse_burst_controller.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/pulse_ctrl_pkg.sv
// rtl/pulse_ctrl_pkg.sv - shared state encoding and default widths for the pulse burst controller
package pulse_ctrl_pkg;

    localparam int CNT_W_DEF   = 16;
    localparam int BURST_W_DEF = 8;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_HIGH = 2'd1;
    localparam state_t ST_LOW  = 2'd2;
    localparam state_t ST_DONE = 2'd3;

endpackage

// File: rtl/pulse_timer.sv
// rtl/pulse_timer.sv - loadable down-counter; tc flags the last cycle of a loaded interval
module pulse_timer #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             tc
);

    logic [CNT_W-1:0] cnt_q;

    // A load of N yields exactly N cycles, tc asserted in the final one; stops at zero.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign tc = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/pulse_burst_controller.sv
// rtl/pulse_burst_controller.sv - burst pulse generator FSM; optional o_sent via PULSE_BURST_CNT_EN
module pulse_burst_controller
    import pulse_ctrl_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int BURST_W = BURST_W_DEF
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic               i_abort,
    input  logic [CNT_W-1:0]   i_duration,
    input  logic [CNT_W-1:0]   i_period,
    input  logic [BURST_W-1:0] i_count,
    output logic               o_pulse,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_err
`ifdef PULSE_BURST_CNT_EN
    ,
    output logic [BURST_W-1:0] o_sent
`endif
);

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   dur_q;
    logic [CNT_W-1:0]   per_q;
    logic [BURST_W-1:0] rem_q;
    logic               tmr_load;
    logic [CNT_W-1:0]   tmr_val;
    logic               tc;
    logic               cfg_legal;
    logic               accept;
    logic               reject;
    logic               abort_hit;

    assign cfg_legal = (i_duration != '0) && (i_period > i_duration) && (i_count != '0);
    assign abort_hit = i_abort && (state_q != ST_IDLE);

    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        accept   = 1'b0;
        reject   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_start && !i_abort) begin
                    if (cfg_legal) begin
                        accept   = 1'b1;
                        state_d  = ST_HIGH;
                        tmr_load = 1'b1;
                        tmr_val  = i_duration;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            ST_HIGH: begin
                if (tc) begin
                    state_d  = ST_LOW;
                    tmr_load = 1'b1;
                    tmr_val  = per_q - dur_q;
                end
            end
            ST_LOW: begin
                if (tc) begin
                    if (rem_q > BURST_W'(1)) begin
                        state_d  = ST_HIGH;
                        tmr_load = 1'b1;
                        tmr_val  = dur_q;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (abort_hit) begin
            state_d  = ST_IDLE;
            tmr_load = 1'b1;
            tmr_val  = '0;
        end
    end

    pulse_timer #(.CNT_W(CNT_W)) u_timer (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tc       (tc)
    );

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= ST_IDLE;
            dur_q   <= '0;
            per_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                dur_q <= i_duration;
                per_q <= i_period;
                rem_q <= i_count;
            end else if (state_q == ST_LOW && tc && !abort_hit && rem_q > BURST_W'(1)) begin
                rem_q <= rem_q - BURST_W'(1);
            end
        end
    end

    // Outputs are a registered decode of the state, so they trail it by one cycle;
    // an abort clears them on the same edge that returns the FSM to IDLE.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_pulse <= 1'b0;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
            o_err   <= 1'b0;
        end else begin
            o_pulse <= !abort_hit && (state_q == ST_HIGH);
            o_busy  <= !abort_hit && (state_q != ST_IDLE);
            o_done  <= !abort_hit && (state_q == ST_DONE);
            o_err   <= reject;
        end
    end

`ifdef PULSE_BURST_CNT_EN
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_sent <= '0;
        end else if (accept) begin
            o_sent <= '0;
        end else if (state_q == ST_HIGH && tc && !abort_hit) begin
            o_sent <= o_sent + BURST_W'(1);
        end
    end
`endif

endmodule
